bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 106 ++++++++++
 tb/tb_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master to one-slave bus arbiter with fair tie-break and wait timeout
module bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [19:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic        m0_mio_i,
  input  logic        m0_byte_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [19:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic        m1_mio_i,
  input  logic        m1_byte_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [19:0] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic        s_we_o,
  output logic        s_mio_o,
  output logic        s_byte_o,
  output logic        s_stb_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       own0, own1, own_stb, hit_to, timeout;

  assign own0    = (state == OWN0);
  assign own1    = (state == OWN1);
  assign own_stb = own1 ? m1_stb_i : (own0 & m0_stb_i);
  assign hit_to  = (own0 | own1) && (cnt == TIMEOUT);
  // A slave ack arriving in the timeout cycle still counts as a normal completion.
  assign timeout = own_stb & hit_to & ~s_ack_i;

  assign s_adr_o  = own1 ? m1_adr_i  : m0_adr_i;
  assign s_dat_o  = own1 ? m1_dat_i  : m0_dat_i;
  assign s_we_o   = own1 ? m1_we_i   : m0_we_i;
  assign s_mio_o  = own1 ? m1_mio_i  : m0_mio_i;
  assign s_byte_o = own1 ? m1_byte_i : m0_byte_i;
  assign s_stb_o  = own_stb & ~timeout;
  assign gnt_o    = {own1, own0};

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 & m0_stb_i & (s_ack_i | hit_to);
  assign m1_ack_o = own1 & m1_stb_i & (s_ack_i | hit_to);
  assign m0_err_o = own0 & timeout;
  assign m1_err_o = own1 & timeout;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = 8'd0;
        if (m0_stb_i && (!m1_stb_i || last)) begin
          state_nxt = OWN0;
          last_nxt  = 1'b0;
        end else if (m1_stb_i) begin
          state_nxt = OWN1;
          last_nxt  = 1'b1;
        end
      end
      default: begin
        // Abort, completion and timeout all return to IDLE; an unused encoding does too.
        if (!own_stb || s_ack_i || hit_to) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with an ownership-level model
module tb_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] m0_adr = '0, m1_adr = '0;
  logic [15:0] m0_dat = '0, m1_dat = '0;
  logic        m0_we = 0, m0_mio = 0, m0_byte = 0, m0_stb = 0;
  logic        m1_we = 0, m1_mio = 0, m1_byte = 0, m1_stb = 0;
  logic [15:0] s_dat = '0;
  logic        s_ack = 0;
  logic [15:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [19:0] s_adr_o;
  logic        s_we_o, s_mio_o, s_byte_o, s_stb_o;
  logic [1:0]  gnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we),
    .m0_mio_i(m0_mio), .m0_byte_i(m0_byte), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we),
    .m1_mio_i(m1_mio), .m1_byte_i(m1_byte), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_mio_o(s_mio_o),
    .s_byte_o(s_byte_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .gnt_o(gnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 = nobody), who was served last, and which owned cycle this is.
  int owner = -1, last_srv = 1, ownc = 0;
  int n_owner, n_last, n_ownc;

  always @(negedge clk) begin
    logic st[2];
    logic tout, e_stb, e_ack0, e_ack1, e_err0, e_err1;
    logic [1:0] e_gnt;
    st[0] = m0_stb;
    st[1] = m1_stb;
    if (rst) begin
      e_gnt = 2'b00; e_stb = 0; e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
      n_owner = -1; n_last = 1; n_ownc = 0;
    end else begin
      tout   = (owner >= 0) && (ownc == TO + 1);
      e_gnt  = (owner < 0) ? 2'b00 : 2'(1 << owner);
      e_stb  = (owner >= 0) && st[owner] && !(tout && !s_ack);
      e_ack0 = (owner == 0) && m0_stb && (s_ack || tout);
      e_ack1 = (owner == 1) && m1_stb && (s_ack || tout);
      e_err0 = (owner == 0) && m0_stb && tout && !s_ack;
      e_err1 = (owner == 1) && m1_stb && tout && !s_ack;
      n_owner = owner; n_last = last_srv; n_ownc = ownc;
      if (owner < 0) begin
        if (m0_stb && m1_stb) n_owner = 1 - last_srv;
        else if (m0_stb)      n_owner = 0;
        else if (m1_stb)      n_owner = 1;
        if (n_owner >= 0) begin
          n_last = n_owner;
          n_ownc = 1;
        end
      end else if (!st[owner] || s_ack || tout) begin
        n_owner = -1;
        n_ownc  = 0;
      end else begin
        n_ownc = ownc + 1;
      end
    end
    check("gnt_o", 32'(gnt_o), 32'(e_gnt));
    check("s_stb_o", 32'(s_stb_o), 32'(e_stb));
    check("m0_ack_o", 32'(m0_ack_o), 32'(e_ack0));
    check("m1_ack_o", 32'(m1_ack_o), 32'(e_ack1));
    check("m0_err_o", 32'(m0_err_o), 32'(e_err0));
    check("m1_err_o", 32'(m1_err_o), 32'(e_err1));
    if (owner == 1 && !rst)
      check("s_fields", {s_adr_o, s_we_o, s_mio_o, s_byte_o}, {m1_adr, m1_we, m1_mio, m1_byte});
    else
      check("s_fields", {s_adr_o, s_we_o, s_mio_o, s_byte_o}, {m0_adr, m0_we, m0_mio, m0_byte});
    check("s_dat_o", 32'(s_dat_o), (owner == 1 && !rst) ? 32'(m1_dat) : 32'(m0_dat));
    check("m_dat_o", {m0_dat_o, m1_dat_o}, {s_dat, s_dat});
  end

  always @(posedge clk) begin
    if (rst) begin
      owner = -1; last_srv = 1; ownc = 0;
    end else begin
      owner = n_owner; last_srv = n_last; ownc = n_ownc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tie_exp [8];
    int lat;
    tie_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    tick(); tick();
    check("reset_gnt", 32'(gnt_o), 32'h0);
    check("reset_stb", 32'(s_stb_o), 32'h0);
    rst = 0;
    tick();
    // Slave ack in IDLE must be ignored.
    s_ack = 1;
    tick();
    check("idle_ack_ignored", {m0_ack_o, m1_ack_o}, 32'h0);
    s_ack = 0;

    // Single m0 read; slave acks two cycles after the strobe rises.
    m0_adr = 20'h12345; m0_mio = 1; m0_we = 0; m0_stb = 1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_stb_o && lat < 10);
    check("req_latency", 32'(lat), 32'd1);
    check("single_adr", 32'(s_adr_o), 32'h12345);
    tick();
    m0_dat = 16'h5A5A;
    tick();
    s_ack = 1; s_dat = 16'hBEEF;
    #1;
    check("single_ack", 32'(m0_ack_o), 32'h1);
    check("single_dat", 32'(m0_dat_o), 32'hBEEF);
    check("single_gnt", 32'(gnt_o), 32'h1);
    tick();
    s_ack = 0; m0_stb = 0;
    check("single_ack_pulse", 32'(m0_ack_o), 32'h0);
    check("single_gnt_idle", 32'(gnt_o), 32'h0);

    // Tie after reset with an immediately acking slave.
    rst = 1;
    tick();
    rst = 0;
    m0_stb = 1; m1_stb = 1; m1_adr = 20'hABCDE;
    for (int i = 0; i < 8; i++) begin
      tick();
      s_ack = (gnt_o != 2'b00);
      check($sformatf("tie_gnt%0d", i), 32'(gnt_o), 32'(tie_exp[i]));
    end
    tick();
    s_ack = 0; m0_stb = 0; m1_stb = 0;
    tick();

    // Timeout: m1 write, slave silent.
    m1_we = 1; m1_dat = 16'h1234; m1_stb = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("to_ack%0d", k), 32'(m1_ack_o), 32'(k == 5));
      check($sformatf("to_err%0d", k), 32'(m1_err_o), 32'(k == 5));
    end
    check("to_stb_low", 32'(s_stb_o), 32'h0);
    tick();
    m1_stb = 0;
    check("to_idle", 32'(gnt_o), 32'h0);
    tick();

    // Ack coinciding with the timeout cycle.
    m1_stb = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) begin
        s_ack = 1;
        #1;
        check("ackto_ack", 32'(m1_ack_o), 32'h1);
        check("ackto_err", 32'(m1_err_o), 32'h0);
      end
    end
    tick();
    s_ack = 0; m1_stb = 0;
    tick();

    // Abort: m0 owns, drops its strobe while m1 waits.
    m0_stb = 1; m1_stb = 1;
    tick();
    check("abort_own0", 32'(gnt_o), 32'h1);
    m0_stb = 0;
    #1;
    check("abort_no_ack", 32'(m0_ack_o), 32'h0);
    tick();
    check("abort_idle", 32'(gnt_o), 32'h0);
    tick();
    check("abort_own1", 32'(gnt_o), 32'h2);
    s_ack = 1;
    #1;
    check("abort_m1_ack", 32'(m1_ack_o), 32'h1);
    tick();
    s_ack = 0; m1_stb = 0;
    tick();

    // Asynchronous reset in the middle of an OWN1 cycle.
    m1_stb = 1;
    tick();
    check("arst_own1", 32'(gnt_o), 32'h2);
    #2;
    rst = 1;
    #1;
    check("arst_stb", 32'(s_stb_o), 32'h0);
    check("arst_gnt", 32'(gnt_o), 32'h0);
    m0_stb = 1;
    tick();
    rst = 0;
    tick();
    check("arst_tie_m0", 32'(gnt_o), 32'h1);
    s_ack = 1;
    tick();
    s_ack = 0; m0_stb = 0; m1_stb = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
